ahb_frame_serializer: RTL and testbench

- Upstream neighbour of mapper1: packs one AHB/APB transaction into the fixed 100-bit serial frame that mapper1 decodes.
- Shifts the frame out MSB first, one bit per clk; serial_out drives mapper1's data_from_slave.
- Replaces the ad-hoc bit-banging in benches and connects the Raspberry Pi command path to the bridge on Artix-7.

---
 rtl/bridge_frame_pkg.sv | 46 ++++
 rtl/ahb_frame_serializer_hold_reg.sv | 47 ++++
 rtl/ahb_frame_serializer.sv | 131 +++++++++++++
 tb/tb_ahb_frame_serializer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_frame_pkg.sv
// Shared definitions for the 100-bit AHB/APB bridge frame.
// Used by the serializer (producer) and mapper1 (consumer).
//   FRAME_BITS      : total frame length
//   *_BIT/_MSB/_LSB : field positions inside the frame word
//   frame_state_e   : serializer FSM encoding
//   pack_frame()    : builds a frame word from its fields
package bridge_frame_pkg;

    localparam int FRAME_BITS = 100;

    localparam int HREADY_BIT = 99;
    localparam int HWRITE_BIT = 98;
    localparam int HTRANS_MSB = 97;
    localparam int HTRANS_LSB = 96;
    localparam int HADDR_MSB  = 95;
    localparam int HWDATA_MSB = 63;
    localparam int PRDATA_MSB = 31;

    typedef logic [FRAME_BITS-1:0] frame_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } frame_state_e;

    function automatic frame_t pack_frame(
        input logic        hreadyin,
        input logic        hwrite,
        input logic [1:0]  htrans,
        input logic [31:0] haddr,
        input logic [31:0] hwdata,
        input logic [31:0] prdata
    );
        frame_t f;
        f                           = '0;
        f[HREADY_BIT]               = hreadyin;
        f[HWRITE_BIT]               = hwrite;
        f[HTRANS_MSB:HTRANS_LSB]    = htrans;
        f[HADDR_MSB -: 32]          = haddr;
        f[HWDATA_MSB -: 32]         = hwdata;
        f[PRDATA_MSB -: 32]         = prdata;
        return f;
    endfunction

endpackage

// File: rtl/ahb_frame_serializer_hold_reg.sv
// frame_hold_reg: one-entry pending-frame register with a registered ready flag.
//   clk, reset_n : clock, synchronous active-low reset
//   in_valid     : source offers a frame
//   in_data      : frame word from the source
//   bypass       : the accepted frame goes straight to the shifter, do not store it
//   take         : the shifter consumes the stored frame this edge
//   in_ready     : registered !hold_full (0 while in reset)
//   hold_full    : a frame is pending
//   hold_data    : the pending frame
module frame_hold_reg #(
    parameter int W = 100
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         bypass,
    input  logic         take,
    output logic         in_ready,
    output logic         hold_full,
    output logic [W-1:0] hold_data
);

    logic capture;
    logic full_next;

    always_comb begin
        capture   = in_valid & in_ready & ~bypass;
        full_next = (hold_full & ~take) | capture;
    end

    // in_ready is its own flop so the source never sees a path from in_valid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_full <= 1'b0;
            in_ready  <= 1'b0;
            hold_data <= '0;
        end else begin
            hold_full <= full_next;
            in_ready  <= ~full_next;
            if (capture) begin
                hold_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/ahb_frame_serializer.sv
// ahb_frame_serializer: packs one AHB/APB transaction into the 100-bit bridge
// frame and shifts it out MSB first, one bit per clk, toward mapper1.
//   clk, reset_n         : clock, synchronous active-low reset
//   in_valid / in_ready  : transaction handshake
//   in_hreadyin..prdata  : frame fields (bits 99 .. 0)
//   serial_out           : serial frame bit (mapper1 data_from_slave)
//   frame_active         : a frame bit is on serial_out
//   frame_done           : pulse in the cycle carrying frame bit 0
//
// state    | meaning
// ST_IDLE  | serial_out idle; start a frame from the hold reg or a direct accept
// ST_SHIFT | bit_cnt is the index of the bit currently on serial_out
// ST_GAP   | forced idle cycles between frames, gap_cnt counts down to 1
module ahb_frame_serializer #(
    parameter int   FRAME_BITS = bridge_frame_pkg::FRAME_BITS,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_hreadyin,
    input  logic        in_hwrite,
    input  logic [1:0]  in_htrans,
    input  logic [31:0] in_haddr,
    input  logic [31:0] in_hwdata,
    input  logic [31:0] in_prdata,
    output logic        serial_out,
    output logic        frame_active,
    output logic        frame_done
);
    import bridge_frame_pkg::*;

    frame_state_e          state;
    logic [FRAME_BITS-1:0] shift_q;
    logic [6:0]            bit_cnt;
    logic [7:0]            gap_cnt;

    logic [FRAME_BITS-1:0] in_frame;
    logic [FRAME_BITS-1:0] next_frame;
    logic [FRAME_BITS-1:0] hold_data;
    logic                  hold_full;
    logic                  accept;
    logic                  may_start;
    logic                  load;
    logic                  take;
    logic                  bypass;

    // A frame may start from IDLE, right after bit 0 when no gap is forced, or
    // at the last gap cycle. The hold register has priority; otherwise a frame
    // accepted on that same edge skips the hold register entirely.
    always_comb begin
        in_frame   = pack_frame(in_hreadyin, in_hwrite, in_htrans,
                                in_haddr, in_hwdata, in_prdata);
        accept     = in_valid & in_ready;
        may_start  = (state == ST_IDLE)
                   | ((state == ST_SHIFT) & (bit_cnt == 7'd0) & (GAP_CYCLES == 0))
                   | ((state == ST_GAP) & (gap_cnt == 8'd1));
        load       = may_start & (hold_full | accept);
        take       = load & hold_full;
        bypass     = load & ~hold_full;
        next_frame = hold_full ? hold_data : in_frame;
    end

    frame_hold_reg #(
        .W (FRAME_BITS)
    ) u_hold (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_frame),
        .bypass    (bypass),
        .take      (take),
        .in_ready  (in_ready),
        .hold_full (hold_full),
        .hold_data (hold_data)
    );

    // shift_q holds the bits not yet presented; serial_out already carries the
    // current one, so the load puts bit 99 out and keeps bits 98..0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            serial_out   <= IDLE_LEVEL;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (load) begin
                state        <= ST_SHIFT;
                serial_out   <= next_frame[FRAME_BITS-1];
                shift_q      <= {next_frame[FRAME_BITS-2:0], 1'b0};
                bit_cnt      <= 7'(FRAME_BITS - 1);
                frame_active <= 1'b1;
            end else begin
                case (state)
                    ST_SHIFT: begin
                        if (bit_cnt != 7'd0) begin
                            serial_out <= shift_q[FRAME_BITS-1];
                            shift_q    <= {shift_q[FRAME_BITS-2:0], 1'b0};
                            bit_cnt    <= bit_cnt - 7'd1;
                            frame_done <= (bit_cnt == 7'd1);
                        end else begin
                            state        <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                            gap_cnt      <= 8'(GAP_CYCLES);
                            serial_out   <= IDLE_LEVEL;
                            frame_active <= 1'b0;
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == 8'd1) begin
                            state <= ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt - 8'd1;
                        end
                    end
                    default: begin
                        state        <= ST_IDLE;
                        serial_out   <= IDLE_LEVEL;
                        frame_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ahb_frame_serializer.sv
// Directed bench for ahb_frame_serializer: one instance with no gap, one with a
// three-cycle gap. A negedge monitor pops expected frames from a queue.
module tb_ahb_frame_serializer;

    typedef logic [99:0] frame_t;

    logic        clk;
    logic        reset_n;
    logic        in_valid0, in_valid3;
    logic        in_ready0, in_ready3;
    logic        in_hreadyin, in_hwrite;
    logic [1:0]  in_htrans;
    logic [31:0] in_haddr, in_hwdata, in_prdata;
    logic        so0, fa0, fd0;
    logic        so3, fa3, fd3;

    int n_tests = 0;
    int n_fail  = 0;
    frame_t exp_q[$];

    ahb_frame_serializer #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_hreadyin(in_hreadyin), .in_hwrite(in_hwrite), .in_htrans(in_htrans),
        .in_haddr(in_haddr), .in_hwdata(in_hwdata), .in_prdata(in_prdata),
        .serial_out(so0), .frame_active(fa0), .frame_done(fd0)
    );

    ahb_frame_serializer #(.GAP_CYCLES(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_hreadyin(in_hreadyin), .in_hwrite(in_hwrite), .in_htrans(in_htrans),
        .in_haddr(in_haddr), .in_hwdata(in_hwdata), .in_prdata(in_prdata),
        .serial_out(so3), .frame_active(fa3), .frame_done(fd3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input frame_t f);
        {in_hreadyin, in_hwrite, in_htrans, in_haddr, in_hwdata, in_prdata} = f;
    endtask

    function automatic frame_t rand_frame();
        logic [31:0] a, b, c;
        logic [3:0]  d;
        a = $urandom;
        b = $urandom;
        c = $urandom;
        d = 4'($urandom);
        return {d, a, b, c};
    endfunction

    task automatic send0(input frame_t f);
        int guard;
        guard = 0;
        while (in_ready0 !== 1'b1 && guard < 300) begin
            tick();
            guard++;
        end
        check("send0_ready", 128'(in_ready0), 128'(1));
        set_fields(f);
        in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        exp_q.push_back(f);
    endtask

    task automatic observe0(output frame_t bits, output int done_cnt, output int done_at,
                            output int inactive);
        bits = '0;
        done_cnt = 0;
        done_at = 0;
        inactive = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            bits = {bits[98:0], so0};
            if (fd0) begin
                done_cnt++;
                done_at = k;
            end
            if (!fa0) inactive++;
        end
    endtask

    // Monitor: rebuilds each frame of dut0 and compares it with the scoreboard.
    frame_t acc0;
    int     nbit0 = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            nbit0 = 0;
        end else if (fa0) begin
            acc0 = {acc0[98:0], so0};
            nbit0++;
            if (fd0 || nbit0 >= 100) begin
                check("mon_done_pos", {95'd0, fd0, 32'(nbit0)}, {95'd0, 1'b1, 32'd100});
                if (exp_q.size() == 0) begin
                    check("mon_unexpected_frame", 128'(acc0), 128'(0));
                end else begin
                    check("mon_frame", 128'(acc0), 128'(exp_q.pop_front()));
                end
                nbit0 = 0;
            end
        end else begin
            check("mon_idle", {126'd0, so0, fd0}, 128'd0);
        end
    end

    initial begin
        frame_t f1, fa, fb, fg, fh, fe, ff, bits;
        logic [199:0] buf2;
        logic [3:0]   expv;
        int dc, da, ina, acc_cnt, guard, act_cnt, done_cnt;

        reset_n   = 1'b0;
        in_valid0 = 1'b0;
        in_valid3 = 1'b0;
        set_fields('0);

        // Reset values
        repeat (3) tick();
        @(negedge clk);
        check("rst_serial_out", 128'(so0), 128'(0));
        check("rst_frame_active", 128'(fa0), 128'(0));
        check("rst_frame_done", 128'(fd0), 128'(0));
        check("rst_in_ready", 128'(in_ready0), 128'(0));
        tick();
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        check("post_rst_in_ready", 128'(in_ready0), 128'(1));

        // Single known frame, decoded the way mapper1 would
        f1 = {1'b0, 1'b1, 2'b00, 32'h8000000C, 32'hFFFFFFFF, 32'h56781234};
        send0(f1);
        observe0(bits, dc, da, ina);
        check("f1_bits", 128'(bits), 128'(f1));
        check("f1_first4", 128'(bits[99:96]), 128'(4'b0100));
        check("f1_done_cnt", 128'(dc), 128'(1));
        check("f1_done_at", 128'(da), 128'(100));
        check("f1_inactive", 128'(ina), 128'(0));
        check("f1_haddr", 128'(bits[95:64]), 128'(32'h8000000C));
        check("f1_hwdata", 128'(bits[63:32]), 128'(32'hFFFFFFFF));
        check("f1_prdata", 128'(bits[31:0]), 128'(32'h56781234));
        check("f1_hwrite", 128'(bits[98]), 128'(1));
        @(negedge clk);
        check("f1_after_active", {126'd0, fa0, so0}, 128'd0);

        // Back-to-back, no gap: 200 contiguous bits
        tick();
        fa = rand_frame();
        fb = rand_frame();
        set_fields(fa);
        in_valid0 = 1'b1;
        tick();
        exp_q.push_back(fa);
        set_fields(fb);
        buf2 = '0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            buf2 = {buf2[198:0], so0};
            expv = {1'b1, (k == 100 || k == 200), (k == 1 || k >= 101), 1'b0};
            check($sformatf("b2b_cyc%0d", k), {124'd0, fa0, fd0, in_ready0, 1'b0}, 128'(expv));
            if (k == 1) begin
                @(posedge clk);
                #1;
                in_valid0 = 1'b0;
                exp_q.push_back(fb);
            end
        end
        check("b2b_bits_hi", 128'(buf2[199:100]), 128'(fa));
        check("b2b_bits_lo", 128'(buf2[99:0]), 128'(fb));

        // Gap of three idle cycles between frames (dut3)
        tick();
        fg = rand_frame();
        fh = rand_frame();
        set_fields(fg);
        in_valid3 = 1'b1;
        tick();
        set_fields(fh);
        for (int k = 1; k <= 203; k++) begin
            @(negedge clk);
            if (k <= 100)
                expv = {fg[100-k], 1'b1, (k == 100), (k == 1)};
            else if (k <= 103)
                expv = 4'b0000;
            else
                expv = {fh[203-k], 1'b1, (k == 203), 1'b1};
            check($sformatf("gap_cyc%0d", k), {124'd0, so3, fa3, fd3, in_ready3}, 128'(expv));
            if (k == 1) begin
                @(posedge clk);
                #1;
                in_valid3 = 1'b0;
            end
        end

        // in_valid held with changing fields: only accept-edge fields are sent
        tick();
        acc_cnt = 0;
        in_valid0 = 1'b1;
        for (int c = 0; c < 260; c++) begin
            set_fields(rand_frame());
            if (in_ready0) begin
                exp_q.push_back({in_hreadyin, in_hwrite, in_htrans, in_haddr, in_hwdata, in_prdata});
                acc_cnt++;
            end
            tick();
        end
        in_valid0 = 1'b0;
        guard = 0;
        while ((exp_q.size() != 0 || fa0) && guard < 600) begin
            tick();
            guard++;
        end
        check("hold_drain_queue", 128'(exp_q.size()), 128'(0));
        check("hold_accepts", 128'(acc_cnt), 128'(4));

        // Reset during bit 40 with a frame pending
        tick();
        fe = rand_frame();
        ff = rand_frame();
        send0(fe);
        set_fields(ff);
        in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        exp_q.push_back(ff);
        repeat (58) tick();
        @(negedge clk);
        check("abort_bit40", 128'(so0), 128'(fe[40]));
        reset_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_outputs", {125'd0, so0, fa0, fd0}, 128'd0);
        tick();
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        check("abort_ready", 128'(in_ready0), 128'(1));
        act_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (fa0) act_cnt++;
            if (fd0) done_cnt++;
        end
        check("abort_no_bits", 128'(act_cnt), 128'(0));
        check("abort_no_done", 128'(done_cnt), 128'(0));

        // All-ones and all-zeros frames
        tick();
        send0('1);
        observe0(bits, dc, da, ina);
        check("ones_bits", 128'(bits), 128'({100{1'b1}}));
        check("ones_done_at", {96'd0, 32'(da)}, 128'd100);
        check("ones_done_cnt", 128'(dc), 128'(1));
        @(negedge clk);
        check("ones_end_active", 128'(fa0), 128'(0));
        tick();
        send0('0);
        observe0(bits, dc, da, ina);
        check("zeros_bits", 128'(bits), 128'(0));
        check("zeros_inactive", 128'(ina), 128'(0));
        check("zeros_done_at", 128'(da), 128'(100));
        @(negedge clk);
        check("zeros_end_active", 128'(fa0), 128'(0));

        repeat (3) tick();
        check("final_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
